image_pixel_streamer: RTL and testbench

- Downstream of the image capture stage; feeds the CNN input layer.
- Consumes the latched square image size and the 32-bit packed pixel words written by the host, buffers them in a small FIFO, and unpacks each word into 8-bit pixels.
- Emits one pixel per cycle on a valid/ready stream with row/column coordinates and frame markers.
- Flags any word dropped because the upstream stage has no backpressure.

---
 rtl/image_pixel_streamer_if.sv | 39 +++
 rtl/image_pixel_streamer.sv | 214 +++++++++++++++++++++
 tb/tb_image_pixel_streamer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/image_pixel_streamer_if.sv
// rtl/image_pixel_streamer_if.sv - size/word/pixel stream and status bundle for image_pixel_streamer
interface image_pixel_streamer_if #(
    parameter int DATA_WIDTH          = 32,
    parameter int PIXEL_WIDTH         = 8,
    parameter int MAX_IMAGE_SIZE_LOG2 = 9
);
    logic                         size_valid_i;
    logic [MAX_IMAGE_SIZE_LOG2:0] image_size_i;
    logic                         word_valid_i;
    logic [DATA_WIDTH-1:0]        word_data_i;
    logic                         word_ready_o;
    logic                         pix_valid_o;
    logic                         pix_ready_i;
    logic [PIXEL_WIDTH-1:0]       pix_data_o;
    logic [MAX_IMAGE_SIZE_LOG2:0] pix_row_o;
    logic [MAX_IMAGE_SIZE_LOG2:0] pix_col_o;
    logic                         sof_o;
    logic                         eol_o;
    logic                         eof_o;
    logic                         frame_done_o;
    logic                         busy_o;
    logic                         size_err_o;
    logic                         overflow_o;
    logic [15:0]                  stall_cycles_o;

    modport slave (
        input  size_valid_i, image_size_i, word_valid_i, word_data_i, pix_ready_i,
        output word_ready_o, pix_valid_o, pix_data_o, pix_row_o, pix_col_o,
               sof_o, eol_o, eof_o, frame_done_o, busy_o, size_err_o, overflow_o,
               stall_cycles_o
    );

    modport master (
        output size_valid_i, image_size_i, word_valid_i, word_data_i, pix_ready_i,
        input  word_ready_o, pix_valid_o, pix_data_o, pix_row_o, pix_col_o,
               sof_o, eol_o, eof_o, frame_done_o, busy_o, size_err_o, overflow_o,
               stall_cycles_o
    );
endinterface

// File: rtl/image_pixel_streamer.sv
// rtl/image_pixel_streamer.sv - unpacks host pixel words into a row/col-tagged pixel stream
// Optional stall statistics counter enabled by PIX_STREAM_STATS_EN.
module image_pixel_streamer #(
    parameter int DATA_WIDTH          = 32,
    parameter int PIXEL_WIDTH         = 8,
    parameter int MAX_IMAGE_SIZE      = 512,
    parameter int MAX_IMAGE_SIZE_LOG2 = 9,
    parameter int FIFO_DEPTH          = 4
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    image_pixel_streamer_if.slave bus
);
    localparam int LANES  = DATA_WIDTH / PIXEL_WIDTH;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int SZ_W   = MAX_IMAGE_SIZE_LOG2 + 1;
    localparam int TP_W   = 2 * MAX_IMAGE_SIZE_LOG2 + 2;
    localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = AW + 1;

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t                 state;
    logic [SZ_W-1:0]        img_n;
    logic [TP_W-1:0]        total_pix;
    logic [TP_W-1:0]        total_words;
    logic [TP_W-1:0]        words_accepted;
    logic [TP_W-1:0]        pix_sent;
    logic [SZ_W-1:0]        row_q;
    logic [SZ_W-1:0]        col_q;

    logic [DATA_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [CNT_W-1:0]       fifo_cnt;

    logic [DATA_WIDTH-1:0]  unp_word;
    logic [LANE_W-1:0]      unp_lane;
    logic                   unp_valid;
    logic [PIXEL_WIDTH-1:0] lane_pix [LANES];

    logic [TP_W-1:0]        req_pix;
    logic [TP_W-1:0]        req_words;
    logic                   size_ok;
    logic                   start_frame;
    logic                   streaming;
    logic                   out_ready;
    logic                   unp_take;
    logic                   last_lane;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   fifo_pop;
    logic                   fifo_push;
    logic                   word_ready;
    logic                   pix_hs;
    logic                   eol_n;
    logic                   eof_n;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_pix[g] = unp_word[g*PIXEL_WIDTH +: PIXEL_WIDTH];
    end

    assign req_pix     = TP_W'(bus.image_size_i) * TP_W'(bus.image_size_i);
    assign req_words   = (req_pix + TP_W'(LANES - 1)) / TP_W'(LANES);
    assign size_ok     = (bus.image_size_i != '0) && (bus.image_size_i <= SZ_W'(MAX_IMAGE_SIZE));
    assign start_frame = (state == IDLE) && bus.size_valid_i && size_ok;
    assign streaming   = (state == STREAM);

    assign out_ready   = !bus.pix_valid_o || bus.pix_ready_i;
    assign unp_take    = unp_valid && out_ready;
    // The final word of a frame may carry padding lanes past the last pixel.
    assign last_lane   = (unp_lane == LANE_W'(LANES - 1)) || (pix_sent == total_pix - TP_W'(1));

    assign fifo_empty  = (fifo_cnt == '0);
    assign fifo_full   = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign fifo_pop    = streaming && !fifo_empty && (!unp_valid || (unp_take && last_lane));
    assign word_ready  = streaming && (!fifo_full || fifo_pop) && (words_accepted < total_words);
    assign fifo_push   = bus.word_valid_i && word_ready;
    assign pix_hs      = bus.pix_valid_o && bus.pix_ready_i;

    assign eol_n       = (col_q == img_n - SZ_W'(1));
    assign eof_n       = eol_n && (row_q == img_n - SZ_W'(1));

    assign bus.word_ready_o = word_ready;
    assign bus.busy_o       = streaming;

    always_ff @(posedge wb_clk_i) begin
        if (fifo_push) fifo_mem[wr_ptr] <= bus.word_data_i;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state            <= IDLE;
            img_n            <= '0;
            total_pix        <= '0;
            total_words      <= '0;
            words_accepted   <= '0;
            pix_sent         <= '0;
            row_q            <= '0;
            col_q            <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            fifo_cnt         <= '0;
            unp_word         <= '0;
            unp_lane         <= '0;
            unp_valid        <= 1'b0;
            bus.pix_valid_o  <= 1'b0;
            bus.pix_data_o   <= '0;
            bus.pix_row_o    <= '0;
            bus.pix_col_o    <= '0;
            bus.sof_o        <= 1'b0;
            bus.eol_o        <= 1'b0;
            bus.eof_o        <= 1'b0;
            bus.frame_done_o <= 1'b0;
            bus.size_err_o   <= 1'b0;
            bus.overflow_o   <= 1'b0;
        end else begin
            bus.frame_done_o <= 1'b0;
            if ((state != IDLE) && bus.word_valid_i && !word_ready) bus.overflow_o <= 1'b1;

            if (fifo_push) begin
                wr_ptr         <= wr_ptr + AW'(1);
                words_accepted <= words_accepted + TP_W'(1);
            end
            if (fifo_pop) rd_ptr <= rd_ptr + AW'(1);
            if (fifo_push && !fifo_pop)      fifo_cnt <= fifo_cnt + CNT_W'(1);
            else if (!fifo_push && fifo_pop) fifo_cnt <= fifo_cnt - CNT_W'(1);

            if (fifo_pop) begin
                unp_word  <= fifo_mem[rd_ptr];
                unp_lane  <= '0;
                unp_valid <= 1'b1;
            end else if (unp_take) begin
                if (last_lane) unp_valid <= 1'b0;
                else           unp_lane  <= unp_lane + LANE_W'(1);
            end

            // Coordinates track the pixel moving into the output register.
            if (unp_take) begin
                pix_sent <= pix_sent + TP_W'(1);
                if (eol_n) begin
                    col_q <= '0;
                    row_q <= row_q + SZ_W'(1);
                end else begin
                    col_q <= col_q + SZ_W'(1);
                end
            end

            if (out_ready) begin
                bus.pix_valid_o <= unp_valid;
                bus.sof_o       <= unp_valid && (row_q == '0) && (col_q == '0);
                bus.eol_o       <= unp_valid && eol_n;
                bus.eof_o       <= unp_valid && eof_n;
                if (unp_valid) begin
                    bus.pix_data_o <= lane_pix[unp_lane];
                    bus.pix_row_o  <= row_q;
                    bus.pix_col_o  <= col_q;
                end
            end

            case (state)
                IDLE: begin
                    if (bus.size_valid_i) begin
                        if (size_ok) begin
                            state          <= STREAM;
                            img_n          <= bus.image_size_i;
                            total_pix      <= req_pix;
                            total_words    <= req_words;
                            bus.size_err_o <= 1'b0;
                            words_accepted <= '0;
                            pix_sent       <= '0;
                            row_q          <= '0;
                            col_q          <= '0;
                            wr_ptr         <= '0;
                            rd_ptr         <= '0;
                            fifo_cnt       <= '0;
                            unp_valid      <= 1'b0;
                        end else begin
                            bus.size_err_o <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (pix_hs && bus.eof_o) begin
                        state            <= DONE;
                        bus.frame_done_o <= 1'b1;
                    end
                end
                DONE: begin
                    if (!bus.size_valid_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PIX_STREAM_STATS_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            stall_cnt <= '0;
        end else if (start_frame) begin
            stall_cnt <= '0;
        end else if (bus.pix_valid_o && !bus.pix_ready_i && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign bus.stall_cycles_o = stall_cnt;
`else
    assign bus.stall_cycles_o = '0;
`endif
endmodule

// File: tb/tb_image_pixel_streamer.sv
// tb/tb_image_pixel_streamer.sv - scoreboard bench for image_pixel_streamer
module tb_image_pixel_streamer;
    typedef struct packed {
        logic [7:0] d;
        logic [9:0] r;
        logic [9:0] c;
        logic       sof;
        logic       eol;
        logic       eof;
    } pix_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    image_pixel_streamer_if bus ();

    image_pixel_streamer dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .bus      (bus)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    pix_t        sb[$];
    pix_t        mon_exp;
    int          frame_n = 0;
    int          model_idx = 0;
    int          pix_seen = 0;
    int          done_cnt = 0;
    int          done_base = 0;
    int          stall_seen = 0;
    int          cyc = 0;
    int          first_acc_cyc = -1;
    int          first_valid_cyc = -1;
    int          bp_t = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_vec = '0;
    logic [31:0] cur_vec;
    logic [7:0]  acc_mask;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] out_vec();
        return {bus.word_ready_o, bus.pix_valid_o, bus.pix_data_o, bus.pix_row_o, bus.pix_col_o,
                bus.sof_o, bus.eol_o, bus.eof_o, bus.frame_done_o, bus.busy_o, bus.size_err_o,
                bus.overflow_o, bus.stall_cycles_o};
    endfunction

    function automatic logic [31:0] word_of(input int w);
        return {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
    endfunction

    task automatic push_word(input logic [31:0] w);
        pix_t p;
        for (int l = 0; l < 4; l++) begin
            if (model_idx < frame_n * frame_n) begin
                p.d   = w[l*8 +: 8];
                p.r   = 10'(model_idx / frame_n);
                p.c   = 10'(model_idx % frame_n);
                p.sof = (model_idx == 0);
                p.eol = ((model_idx % frame_n) == frame_n - 1);
                p.eof = (model_idx == frame_n * frame_n - 1);
                sb.push_back(p);
                model_idx++;
            end
        end
    endtask

    task automatic start_frame(input int n, input bit hold);
        @(posedge clk); #1;
        bus.size_valid_i = 1'b1;
        bus.image_size_i = 10'(n);
        frame_n = n;
        model_idx = 0;
        pix_seen = 0;
        stall_seen = 0;
        first_acc_cyc = -1;
        first_valid_cyc = -1;
        done_base = done_cnt;
        @(posedge clk); #1;
        if (!hold) bus.size_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        bit ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (bus.word_ready_o) begin
                bus.word_valid_i = 1'b1;
                bus.word_data_i  = w;
                @(posedge clk); #1;
                bus.word_valid_i = 1'b0;
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                push_word(w);
                ok = 1'b1;
            end
        end
        check("word_accepted", ok, 1);
    endtask

    task automatic wait_done(input int limit);
        int t = 0;
        while (done_cnt == done_base && t < limit) begin
            @(negedge clk);
            t++;
        end
        check("frame_done_seen", done_cnt > done_base, 1);
        repeat (4) @(negedge clk);
        check("frame_done_once", done_cnt - done_base, 1);
        check("sb_drained", sb.size(), 0);
        check("pix_count", pix_seen, frame_n * frame_n);
        check("busy_after_done", bus.busy_o, 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scoreboard pop, stall stability and event counters.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            cur_vec = {bus.pix_valid_o, bus.pix_data_o, bus.pix_row_o, bus.pix_col_o,
                       bus.sof_o, bus.eol_o, bus.eof_o};
            if (prev_stall) check("stall_hold", cur_vec, prev_vec);
            if (bus.pix_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bus.pix_valid_o && bus.pix_ready_i) begin
                pix_seen++;
                check("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    mon_exp = sb.pop_front();
                    check("pix", cur_vec[30:0], mon_exp);
                end
            end
            if (bus.pix_valid_o && !bus.pix_ready_i) stall_seen++;
            if (bus.frame_done_o) done_cnt++;
            prev_stall = bus.pix_valid_o && !bus.pix_ready_i;
            prev_vec   = cur_vec;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.size_valid_i = 1'b0;
        bus.image_size_i = '0;
        bus.word_valid_i = 1'b0;
        bus.word_data_i  = '0;
        bus.pix_ready_i  = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", out_vec(), 0);
        rst_n = 1'b1;

        // Basic 4x4 frame, size_valid held high through DONE.
        start_frame(4, 1'b1);
        for (int w = 0; w < 4; w++) send_word(word_of(w));
        wait_done(100);
        check("latency", first_valid_cyc - first_acc_cyc, 2);
        repeat (3) @(negedge clk);
        check("held_size_no_restart", bus.busy_o, 0);
        check("done_word_ready", bus.word_ready_o, 0);
        bus.size_valid_i = 1'b0;
        repeat (2) @(negedge clk);

        // Backpressure with pix_ready toggling every cycle.
        start_frame(4, 1'b0);
        fork
            begin
                for (int w = 0; w < 4; w++) send_word(word_of(w));
            end
            begin
                bp_t = 0;
                while (done_cnt == done_base && bp_t < 300) begin
                    @(posedge clk); #1;
                    bus.pix_ready_i = ~bus.pix_ready_i;
                    bp_t++;
                end
            end
        join
        bus.pix_ready_i = 1'b1;
        wait_done(50);
        check("bp_stalls_seen", stall_seen != 0, 1);
`ifdef PIX_STREAM_STATS_EN
        check("stall_cycles", bus.stall_cycles_o, stall_seen);
`else
        check("stall_cycles_off", bus.stall_cycles_o, 0);
`endif

        // Invalid sizes, then recovery with N=2.
        start_frame(0, 1'b0);
        @(negedge clk);
        check("size0_err", bus.size_err_o, 1);
        check("size0_busy", bus.busy_o, 0);
        check("size0_ready", bus.word_ready_o, 0);
        start_frame(513, 1'b0);
        @(negedge clk);
        check("size513_err", bus.size_err_o, 1);
        check("size513_busy", bus.busy_o, 0);
        check("size513_ready", bus.word_ready_o, 0);
        start_frame(2, 1'b0);
        @(negedge clk);
        check("size2_err_clear", bus.size_err_o, 0);
        check("size2_busy", bus.busy_o, 1);
        send_word(32'h44332211);
        wait_done(100);

        // Partial last word on a 3x3 frame and a refused fourth word.
        start_frame(3, 1'b0);
        send_word(word_of(0));
        send_word(word_of(1));
        send_word(32'hDDCCBBAA);
        @(negedge clk);
        check("ovf_before", bus.overflow_o, 0);
        check("refuse_4th_ready", bus.word_ready_o, 0);
        bus.word_valid_i = 1'b1;
        bus.word_data_i  = 32'h99999999;
        @(posedge clk); #1;
        bus.word_valid_i = 1'b0;
        @(negedge clk);
        check("ovf_4th_word", bus.overflow_o, 1);
        wait_done(100);

        // FIFO overflow with output stalled.
        apply_reset();
        @(negedge clk);
        check("ovf_cleared_by_reset", bus.overflow_o, 0);
        start_frame(8, 1'b0);
        bus.pix_ready_i = 1'b0;
        acc_mask = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.word_valid_i = 1'b1;
            bus.word_data_i  = word_of(i);
            acc_mask[i] = bus.word_ready_o;
            if (bus.word_ready_o) push_word(word_of(i));
            @(posedge clk);
        end
        #1 bus.word_valid_i = 1'b0;
        @(negedge clk);
        check("ovf_accept_mask", acc_mask, 8'h1F);
        check("ovf_flag", bus.overflow_o, 1);
        check("ovf_pix_held", {bus.pix_valid_o, bus.pix_data_o}, 9'h100);
        bus.pix_ready_i = 1'b1;
        for (int w = 5; w < 16; w++) send_word(word_of(w));
        wait_done(200);

        // Reset in the middle of a frame, then a fresh 2x2 frame.
        start_frame(4, 1'b0);
        for (int w = 0; w < 4; w++) send_word(word_of(w));
        bp_t = 0;
        while (pix_seen < 5 && bp_t < 100) begin
            @(negedge clk); #2;
            bp_t++;
        end
        check("mid_frame_pix5", pix_seen, 5);
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs", out_vec(), 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start_frame(2, 1'b0);
        send_word(32'hD4C3B2A1);
        wait_done(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
